sort_stream_feeder: RTL

//  Streaming front/back end for the 8-entry in-place sorter (start/addr/wr/datain/dataout/ready).
//  - Accepts one frame of 8 bytes on a valid/ready input stream and writes them into sorter slots 0..7.
//  - Pulses start, waits for completion, then reads slots 0..7 back and emits them in ascending order on a valid/ready output stream.
//  - Sits directly upstream and downstream of the sorter; it is the only master of the sorter's port.

---
 rtl/sort_stream_feeder_pkg.sv | 27 ++
 rtl/sort_stream_feeder_if.sv | 52 +++++
 rtl/sort_stream_feeder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sort_stream_feeder_pkg.sv
// ---------------------------------------------------------------------------
// sort_feeder_pkg
// Shared types and constants for the sort_stream_feeder block.
//   SORT_DEPTH     entries per frame (sorter has a 3-bit address)
//   SORT_W         data width of the sorter datain/dataout
//   SORT_PAD       fill value for unused slots of a short frame
//   feeder_state_t feeder FSM encoding (exported on dbg_state)
// Optional feature macro: SORT_FEEDER_PARTIAL_EN (short frames via in_last).
// ---------------------------------------------------------------------------
package sort_feeder_pkg;

  localparam int           SORT_DEPTH = 8;
  localparam int           SORT_W     = 8;
  localparam logic [7:0]   SORT_PAD   = 8'hFF;

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    PAD   = 3'd1,
    KICK  = 3'd2,
    ARM   = 3'd3,
    WAIT  = 3'd4,
    RADDR = 3'd5,
    RCAP  = 3'd6,
    OUT   = 3'd7
  } feeder_state_t;

endpackage

// File: rtl/sort_stream_feeder_if.sv
// ---------------------------------------------------------------------------
// sort_stream_feeder_if
// Input and output byte streams of the sort feeder.
// Handshake: a byte moves on a rising clk edge where valid && ready are both
// 1; the source holds valid and data stable until that edge, and ready may
// be asserted independently of valid.
//   in_valid/in_data/in_ready     upstream byte stream
//   in_last                       last byte of a short frame
//                                 (SORT_FEEDER_PARTIAL_EN only)
//   out_valid/out_data/out_ready  sorted byte stream
// Modports:
//   slave   the feeder side (sink of the input stream, source of the output)
//   master  the environment side (drives input stream, consumes output)
// ---------------------------------------------------------------------------
interface sort_stream_feeder_if;
  import sort_feeder_pkg::*;

  logic              in_valid;
  logic [SORT_W-1:0] in_data;
`ifdef SORT_FEEDER_PARTIAL_EN
  logic              in_last;
`endif
  logic              in_ready;
  logic              out_valid;
  logic [SORT_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
`ifdef SORT_FEEDER_PARTIAL_EN
    input  in_last,
`endif
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
`ifdef SORT_FEEDER_PARTIAL_EN
    output in_last,
`endif
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/sort_stream_feeder.sv
// ---------------------------------------------------------------------------
// sort_stream_feeder
// Streaming front/back end for the 8-entry in-place sorter. Collects one
// frame of 8 bytes into sorter slots 0..7, pulses start, waits for the
// sorter to go idle, then reads slots 0..7 back and emits them in ascending
// order. It is the only master of the sorter port.
// Ports:
//   clk        clock, rising edge
//   nrst       asynchronous active-low reset (shared with the sorter)
//   strm       byte streams (sort_stream_feeder_if.slave)
//   s_start    sorter start pulse
//   s_wr       sorter write enable
//   s_addr     sorter slot address
//   s_datain   sorter write data
//   s_dataout  sorter read data, registered (1-cycle latency)
//   s_ready    sorter idle flag
//   busy       1 in any state other than FILL
//   dbg_state  current FSM state
// Macro SORT_FEEDER_PARTIAL_EN enables short frames: in_last ends the
// frame early, remaining slots are padded with PAD_VALUE and only the
// received number of bytes is emitted.
// ---------------------------------------------------------------------------
module sort_stream_feeder
  import sort_feeder_pkg::*;
#(
  parameter int         DEPTH     = SORT_DEPTH,
`ifdef SORT_FEEDER_PARTIAL_EN
  parameter logic [7:0] PAD_VALUE = SORT_PAD,
`endif
  parameter int         W         = SORT_W
) (
  input  logic                 clk,
  input  logic                 nrst,
  sort_stream_feeder_if.slave  strm,
  output logic                 s_start,
  output logic                 s_wr,
  output logic [2:0]           s_addr,
  output logic [W-1:0]         s_datain,
  input  logic [W-1:0]         s_dataout,
  input  logic                 s_ready,
  output logic                 busy,
  output feeder_state_t        dbg_state
);

  // Highest slot index; the sorter address is 3 bits so this is 7.
  localparam logic [3:0] LAST_SLOT = 4'(DEPTH - 1);

  feeder_state_t  state_q, state_d;
  logic [3:0]     k_q, k_d;
  logic [3:0]     cnt_q;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;

`ifdef SORT_FEEDER_PARTIAL_EN
  logic [3:0]     cnt_d;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= FILL;
      k_q         <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef SORT_FEEDER_PARTIAL_EN
  // Number of valid entries in the current frame, latched when the frame
  // closes (on in_last or on the 8th byte).
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without short frames every frame is full.
  assign cnt_q = 4'(DEPTH);
`endif

  // -------------------------------------------------------------------------
  // Next-state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
`ifdef SORT_FEEDER_PARTIAL_EN
    cnt_d         = cnt_q;
`endif
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    strm.in_ready = 1'b0;
    s_start       = 1'b0;
    s_wr          = 1'b0;
    s_addr        = 3'd0;
    s_datain      = '0;

    case (state_q)
      FILL: begin
        // Input bytes go straight into the sorter slot addressed by k.
        strm.in_ready = 1'b1;
        s_addr        = k_q[2:0];
        s_datain      = strm.in_data;
        s_wr          = strm.in_valid;
        if (strm.in_valid) begin
          k_d = k_q + 4'd1;
          if (k_q == LAST_SLOT) begin
            state_d = KICK;
`ifdef SORT_FEEDER_PARTIAL_EN
            cnt_d   = k_q + 4'd1;
          end else if (strm.in_last) begin
            state_d = PAD;
            cnt_d   = k_q + 4'd1;
`endif
          end
        end
      end

`ifdef SORT_FEEDER_PARTIAL_EN
      PAD: begin
        // Fill the unused slots with a value that sorts last.
        s_wr     = 1'b1;
        s_addr   = k_q[2:0];
        s_datain = PAD_VALUE;
        k_d      = k_q + 4'd1;
        if (k_q == LAST_SLOT) begin
          state_d = KICK;
        end
      end
`endif

      KICK: begin
        s_start = 1'b1;
        state_d = ARM;
      end

      ARM: begin
        // The sorter still reports ready in the start cycle; skip one cycle
        // before trusting s_ready.
        state_d = WAIT;
      end

      WAIT: begin
        if (s_ready) begin
          k_d     = 4'd0;
          state_d = RADDR;
        end
      end

      RADDR: begin
        s_addr  = k_q[2:0];
        state_d = RCAP;
      end

      RCAP: begin
        // Read data for the address issued in RADDR is valid now.
        out_data_d  = s_dataout;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end

      OUT: begin
        if (strm.out_ready) begin
          out_valid_d = 1'b0;
          if (k_q == cnt_q - 4'd1) begin
            k_d     = 4'd0;
`ifdef SORT_FEEDER_PARTIAL_EN
            cnt_d   = 4'd0;
`endif
            state_d = FILL;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = RADDR;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign busy           = (state_q != FILL);
  assign dbg_state      = state_q;

endmodule
